// File: rtl/intra4_sse_select_if.sv
// Bus bundle between the 4x4 intra predictors and the SSE mode selector.
// The master drives the source block and candidate predictions; the slave
// (the selector) returns the handshake ready and the winning result.
interface intra4_sse_select_if #(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 4,
  parameter int MODE_W     = 4,
  parameter int SSE_W      = 20
);

  localparam int BLK_W = BIT_WIDTH * BLOCK_SIZE * BLOCK_SIZE;

  logic              start;
  logic [BLK_W-1:0]  src;
  logic              pred_valid;
  logic              pred_ready;
  logic [BLK_W-1:0]  pred;
  logic [MODE_W-1:0] pred_mode;
  logic              done;
  logic [MODE_W-1:0] best_mode;
  logic [SSE_W-1:0]  best_sse;
  logic [BLK_W-1:0]  best_pred;

  modport master (
    output start, src, pred_valid, pred, pred_mode,
    input  pred_ready, done, best_mode, best_sse, best_pred
  );

  modport slave (
    input  start, src, pred_valid, pred, pred_mode,
    output pred_ready, done, best_mode, best_sse, best_pred
  );

endinterface

// File: rtl/intra4_sse_select.sv
// 4x4 intra mode selector: computes the SSE between the latched source block
// and each of NUM_MODES candidate predictions (one per clock), and keeps the
// candidate with the lowest SSE (earliest wins on ties).
// Pipeline: S1 squared differences, S2 SSE sum, S3 compare/update.
module intra4_sse_select #(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 4,
  parameter int NUM_MODES  = 10,
  parameter int MODE_W     = 4,
  parameter int SSE_W      = 20
) (
  input logic                 clk,
  input logic                 rst,
  intra4_sse_select_if.slave  bus
);

  localparam int NPIX  = BLOCK_SIZE * BLOCK_SIZE;
  localparam int BLK_W = BIT_WIDTH * NPIX;
  localparam int SQ_W  = 2 * BIT_WIDTH;
  localparam int CNT_W = $clog2(NUM_MODES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_MODES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Control state
  state_t            state;
  logic              pred_ready_q;
  logic              done_q;
  logic [CNT_W-1:0]  acc_cnt;
  logic [BLK_W-1:0]  src_q;
  logic              accept;

  // Per-pixel difference / square (combinational ahead of S1)
  logic signed [BIT_WIDTH:0] diff    [NPIX];
  logic [BIT_WIDTH-1:0]      mag     [NPIX];
  logic [SQ_W-1:0]           sq_comb [NPIX];

  // S1 registers
  logic              s1_valid;
  logic              s1_first;
  logic              s1_last;
  logic [MODE_W-1:0] s1_mode;
  logic [BLK_W-1:0]  s1_pred;
  logic [SQ_W-1:0]   s1_sq [NPIX];

  // S2 sum and registers
  logic [SSE_W-1:0]  sse_comb;
  logic              s2_valid;
  logic              s2_first;
  logic              s2_last;
  logic [MODE_W-1:0] s2_mode;
  logic [BLK_W-1:0]  s2_pred;
  logic [SSE_W-1:0]  s2_sse;

  // S3 best-so-far registers
  logic [MODE_W-1:0] best_mode_q;
  logic [SSE_W-1:0]  best_sse_q;
  logic [BLK_W-1:0]  best_pred_q;

  // pred_ready is only ever high in RUN, so this is the true handshake
  assign accept = (state == RUN) && pred_ready_q && bus.pred_valid;

  // Block sequencing: latch src on start, count accepts, wait for the
  // last candidate to leave S2, then pulse done for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pred_ready_q <= 1'b0;
      done_q       <= 1'b0;
      acc_cnt      <= '0;
      src_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            src_q        <= bus.src;
            acc_cnt      <= '0;
            pred_ready_q <= 1'b1;
            state        <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
            if (acc_cnt == LAST_CNT) begin
              pred_ready_q <= 1'b0;
              state        <= DRAIN;
            end
          end
        end
        DRAIN: begin
          pred_ready_q <= 1'b0;
          if (s2_valid && s2_last) begin
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          pred_ready_q <= 1'b0;
          done_q       <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  // Signed 9-bit difference per pixel, squared via its magnitude
  always_comb begin
    for (int i = 0; i < NPIX; i++) begin
      diff[i] = $signed({1'b0, src_q[i*BIT_WIDTH +: BIT_WIDTH]})
              - $signed({1'b0, bus.pred[i*BIT_WIDTH +: BIT_WIDTH]});
      mag[i]  = diff[i][BIT_WIDTH] ? BIT_WIDTH'(-diff[i]) : BIT_WIDTH'(diff[i]);
      sq_comb[i] = SQ_W'(mag[i]) * SQ_W'(mag[i]);
    end
  end

  // S1 valid/position flags; cleared on reset so in-flight work is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_first <= accept && (acc_cnt == '0);
      s1_last  <= accept && (acc_cnt == LAST_CNT);
    end
  end

  // S1 payload: squares, mode and prediction of the accepted candidate
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_mode <= bus.pred_mode;
      s1_pred <= bus.pred;
      for (int i = 0; i < NPIX; i++) begin
        s1_sq[i] <= sq_comb[i];
      end
    end
  end

  // Adder tree over the squares; SSE_W holds the all-255 worst case
  always_comb begin
    sse_comb = '0;
    for (int i = 0; i < NPIX; i++) begin
      sse_comb = sse_comb + SSE_W'(s1_sq[i]);
    end
  end

  // S2 valid/position flags
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_first <= s1_valid && s1_first;
      s2_last  <= s1_valid && s1_last;
    end
  end

  // S2 payload: summed SSE travelling with its mode and prediction
  always_ff @(posedge clk) begin
    if (s1_valid) begin
      s2_sse  <= sse_comb;
      s2_mode <= s1_mode;
      s2_pred <= s1_pred;
    end
  end

  // S3: first candidate loads unconditionally, later ones only if strictly
  // better, so ties keep the earlier candidate
  always_ff @(posedge clk) begin
    if (rst) begin
      best_mode_q <= '0;
      best_sse_q  <= '0;
      best_pred_q <= '0;
    end else if (s2_valid && (s2_first || (s2_sse < best_sse_q))) begin
      best_mode_q <= s2_mode;
      best_sse_q  <= s2_sse;
      best_pred_q <= s2_pred;
    end
  end

  assign bus.pred_ready = pred_ready_q;
  assign bus.done       = done_q;
  assign bus.best_mode  = best_mode_q;
  assign bus.best_sse   = best_sse_q;
  assign bus.best_pred  = best_pred_q;

endmodule
